// File: rtl/btn_pkg.sv
// Shared types and sizing helper for the push-button conditioner.
package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_DEB,
        PRESSED,
        RELEASE_DEB
    } btn_state_t;

    // Counter width large enough to hold the largest configured cycle count.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchronizer, debounce FSM and registered pulses.
// Optional hold-to-repeat behaviour is enabled by defining BTN_AUTOREPEAT_EN.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic key_n,
    output logic key_clean_n,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    btn_state_t       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_inc;
    logic             repeat_hit;

    // Saturating increment; the comparison happens on the incremented value so
    // the accepted change lands DEBOUNCE_CYCLES+2 edges after the raw edge.
    assign cnt_inc = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_W'(1);

`ifdef BTN_AUTOREPEAT_EN
    logic [CNT_W-1:0] hold_reg;
    logic [CNT_W-1:0] hold_inc;
    logic             rep_phase_reg;

    assign hold_inc   = (&hold_reg) ? hold_reg : hold_reg + CNT_W'(1);
    assign repeat_hit = rep_phase_reg ? (hold_inc == CNT_W'(REPEAT_RATE))
                                      : (hold_inc == CNT_W'(REPEAT_DELAY));

    // Hold counter only runs while the key sits steadily in PRESSED.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            hold_reg      <= '0;
            rep_phase_reg <= 1'b0;
        end else if (state_reg == PRESSED && !sync2_reg) begin
            if (repeat_hit) begin
                hold_reg      <= '0;
                rep_phase_reg <= 1'b1;
            end else begin
                hold_reg <= hold_inc;
            end
        end else begin
            hold_reg      <= '0;
            rep_phase_reg <= 1'b0;
        end
    end
`else
    assign repeat_hit = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync1_reg     <= 1'b1;
            sync2_reg     <= 1'b1;
            state_reg     <= RELEASED;
            cnt_reg       <= '0;
            key_clean_n   <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync1_reg     <= key_n;
            sync2_reg     <= sync1_reg;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state_reg)
                RELEASED: begin
                    if (!sync2_reg) begin
                        state_reg <= PRESS_DEB;
                        cnt_reg   <= '0;
                    end
                end
                PRESS_DEB: begin
                    if (sync2_reg) begin
                        state_reg <= RELEASED;
                    end else if (cnt_inc == DEB_LAST) begin
                        state_reg   <= PRESSED;
                        key_clean_n <= 1'b0;
                        press_pulse <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_inc;
                    end
                end
                PRESSED: begin
                    if (sync2_reg) begin
                        state_reg <= RELEASE_DEB;
                        cnt_reg   <= '0;
                    end else if (repeat_hit) begin
                        press_pulse <= 1'b1;
                    end
                end
                RELEASE_DEB: begin
                    if (!sync2_reg) begin
                        state_reg <= PRESSED;
                    end else if (cnt_inc == DEB_LAST) begin
                        state_reg     <= RELEASED;
                        key_clean_n   <= 1'b1;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_inc;
                    end
                end
                default: state_reg <= RELEASED;
            endcase
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Conditions N_KEYS raw active-low buttons into clean levels and press/release pulses.
// Define BTN_AUTOREPEAT_EN to get auto-repeat press pulses while a key is held.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_KEYS          = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_clean_n,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse
);

    generate
        for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_ch
            btn_channel #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .REPEAT_DELAY   (REPEAT_DELAY),
                .REPEAT_RATE    (REPEAT_RATE)
            ) u_ch (
                .Clk          (Clk),
                .Reset        (Reset),
                .key_n        (key_n[gi]),
                .key_clean_n  (key_clean_n[gi]),
                .press_pulse  (press_pulse[gi]),
                .release_pulse(release_pulse[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random key activity against a run-length model.
module tb_btn_conditioner;

    localparam int NK = 2;
    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RR = 5;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [NK-1:0] key_n;
    logic [NK-1:0] key_clean_n;
    logic [NK-1:0] press_pulse;
    logic [NK-1:0] release_pulse;

    always #5 Clk = ~Clk;

    btn_conditioner #(
        .N_KEYS         (NK),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .key_n        (key_n),
        .key_clean_n  (key_clean_n),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    int tests  = 0;
    int failed = 0;

    // Model: clean level flips once the synchronized input has disagreed with
    // it for D consecutive edges; hold time counts steady pressed edges.
    logic          m_s1    [NK];
    logic          m_s2    [NK];
    logic          m_clean [NK];
    int            m_run   [NK];
    int            m_hold  [NK];
    logic [NK-1:0] m_press;
    logic [NK-1:0] m_rel;

    int edge_no;
    int press_cnt   [NK];
    int rel_cnt     [NK];
    int first_press [NK];
    int press_edges1[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NK; c++) begin
            m_s1[c]    = 1'b1;
            m_s2[c]    = 1'b1;
            m_clean[c] = 1'b1;
            m_run[c]   = 0;
            m_hold[c]  = 0;
        end
        m_press = '0;
        m_rel   = '0;
    endtask

    task automatic model_step();
        logic s;
        m_press = '0;
        m_rel   = '0;
        for (int c = 0; c < NK; c++) begin
            s       = m_s2[c];
            m_s2[c] = m_s1[c];
            m_s1[c] = key_n[c];
            if (s != m_clean[c]) begin
                m_hold[c] = 0;
                m_run[c]++;
                if (m_run[c] == D) begin
                    m_run[c]   = 0;
                    m_clean[c] = s;
                    if (s == 1'b0) m_press[c] = 1'b1;
                    else           m_rel[c]   = 1'b1;
                end
            end else if (m_run[c] > 0) begin
                m_run[c]  = 0;
                m_hold[c] = 0;
            end else if (m_clean[c] == 1'b0) begin
                m_hold[c]++;
`ifdef BTN_AUTOREPEAT_EN
                if (m_hold[c] == RD || (m_hold[c] > RD && (m_hold[c] - RD) % RR == 0))
                    m_press[c] = 1'b1;
`endif
            end
        end
    endtask

    task automatic clear_stats();
        edge_no = 0;
        for (int c = 0; c < NK; c++) begin
            press_cnt[c]   = 0;
            rel_cnt[c]     = 0;
            first_press[c] = -1;
        end
        press_edges1.delete();
    endtask

    task automatic tick();
        logic [NK-1:0] mc;
        @(posedge Clk);
        if (Reset) model_step();
        else       model_reset();
        #1;
        for (int c = 0; c < NK; c++) mc[c] = m_clean[c];
        chk("clean", key_clean_n, mc);
        chk("press", press_pulse, m_press);
        chk("release", release_pulse, m_rel);
        chk("pulse_excl", press_pulse & release_pulse, '0);
        edge_no++;
        for (int c = 0; c < NK; c++) begin
            if (press_pulse[c] === 1'b1) begin
                press_cnt[c]++;
                if (first_press[c] < 0) first_press[c] = edge_no;
                if (c == 1) press_edges1.push_back(edge_no);
            end
            if (release_pulse[c] === 1'b1) rel_cnt[c]++;
        end
    endtask

    initial begin
        int exp_rep[5];
        int prob;
        exp_rep = '{6, 26, 31, 36, 41};

        // Step 1: both keys held low through reset
        Reset = 1'b0;
        key_n = 2'b00;
        model_reset();
        clear_stats();
        repeat (3) tick();
        chk("t1_clean_rst", key_clean_n, 2'b11);
        chk("t1_press_rst", press_pulse, 2'b00);
        clear_stats();
        Reset = 1'b1;
        repeat (8) tick();
        chk("t1_edge_k0", first_press[0], 6);
        chk("t1_edge_k1", first_press[1], 6);
        $display("[TB] step 1: press after reset release at edges %0d/%0d", first_press[0], first_press[1]);
        key_n = 2'b11;
        repeat (10) tick();

        // Step 2: clean press on key 0
        clear_stats();
        key_n[0] = 1'b0;
        repeat (10) tick();
        chk("t2_edge", first_press[0], 6);
        chk("t2_count", press_cnt[0], 1);
        chk("t2_clean", key_clean_n[0], 1'b0);
        $display("[TB] step 2: press pulse at edge %0d, count %0d", first_press[0], press_cnt[0]);

        // Step 4: release with a 2-cycle low bounce
        clear_stats();
        key_n[0] = 1'b1;
        repeat (3) tick();
        key_n[0] = 1'b0;
        repeat (2) tick();
        key_n[0] = 1'b1;
        repeat (10) tick();
        chk("t4_rel_count", rel_cnt[0], 1);
        chk("t4_press_count", press_cnt[0], 0);
        chk("t4_clean", key_clean_n[0], 1'b1);
        $display("[TB] step 4: release pulses %0d", rel_cnt[0]);

        // Step 3: 3-cycle press bounce is rejected
        clear_stats();
        key_n[0] = 1'b0;
        repeat (3) tick();
        key_n[0] = 1'b1;
        repeat (10) tick();
        chk("t3_press_count", press_cnt[0], 0);
        chk("t3_clean", key_clean_n[0], 1'b1);
        $display("[TB] step 3: bounce press pulses %0d", press_cnt[0]);

        // Step 5: reset in the middle of press debounce
        clear_stats();
        key_n[0] = 1'b0;
        repeat (5) tick();
        Reset = 1'b0;
        model_reset();
        #1;
        chk("t5_clean", key_clean_n, 2'b11);
        chk("t5_press", press_pulse, 2'b00);
        chk("t5_release", release_pulse, 2'b00);
        repeat (2) tick();
        key_n = 2'b11;
        Reset = 1'b1;
        repeat (10) tick();
        chk("t5_no_press", press_cnt[0], 0);
        chk("t5_no_rel", rel_cnt[0], 0);
        $display("[TB] step 5: reset mid-debounce, press pulses %0d", press_cnt[0]);

        // Step 6: long hold on key 1
        clear_stats();
        key_n[1] = 1'b0;
        repeat (43) tick();
        key_n[1] = 1'b1;
        repeat (20) tick();
`ifdef BTN_AUTOREPEAT_EN
        chk("t6_rep_count", press_edges1.size(), 5);
        for (int i = 0; i < 5 && i < press_edges1.size(); i++)
            chk("t6_rep_edge", press_edges1[i], exp_rep[i]);
`else
        chk("t6_count", press_cnt[1], 1);
        chk("t6_edge", first_press[1], 6);
`endif
        chk("t6_release", rel_cnt[1], 1);
        $display("[TB] step 6: long hold press pulses %0d", press_cnt[1]);

        // Random phase: bursts of bouncy and steady activity with occasional resets
        clear_stats();
        for (int blk = 0; blk < 12; blk++) begin
            case ($urandom_range(0, 2))
                0:       prob = 3;
                1:       prob = 12;
                default: prob = 45;
            endcase
            for (int t = 0; t < 60; t++) begin
                tick();
                for (int c = 0; c < NK; c++)
                    if ($urandom_range(0, prob - 1) == 0) key_n[c] = ~key_n[c];
                if (!Reset) Reset = 1'b1;
                else if ($urandom_range(0, 199) == 0) Reset = 1'b0;
            end
            $display("[TB] random block %0d: presses %0d/%0d releases %0d/%0d",
                     blk, press_cnt[0], press_cnt[1], rel_cnt[0], rel_cnt[1]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
